// File: rtl/dmux_dispatch.sv
// dmux_dispatch: one-entry handshaked word dispatcher for the DMux fabric.
// Steers each word to one consumer, addressed or round-robin with stall skipping.
module dmux_dispatch #(
    parameter int WIDTH   = 16,
    parameter int N_OUT   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(N_OUT)-1:0] in_sel,
    output logic [N_OUT-1:0]         out_valid,
    input  logic [N_OUT-1:0]         out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(N_OUT)-1:0] rr_ptr,
    output logic [7:0]               sent_cnt,
    output logic [7:0]               skip_cnt
);

    localparam int SW = $clog2(N_OUT);
    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_hold_data;
    logic [SW-1:0]    r_hold_tgt;
    logic             r_hold_mode;
    logic [N_OUT-1:0] r_out_valid;
    logic [SW-1:0]    r_rr_ptr;
    logic [7:0]       r_sent;
    logic [7:0]       r_skip;
    logic [7:0]       r_wait;

    logic          w_full;
    logic          w_fire;
    logic          w_accept;
    logic          w_timeout;
    logic [SW-1:0] w_tgt_inc;
    logic [SW-1:0] w_rr_next;
    logic [SW-1:0] w_load_tgt;

    function automatic logic [N_OUT-1:0] f_onehot(input logic [SW-1:0] idx);
        logic [N_OUT-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign w_full    = (r_state == S_FULL);
    assign w_fire    = w_full && out_ready[r_hold_tgt];
    assign in_ready  = rst_n && (!w_full || w_fire);
    assign w_accept  = in_valid && in_ready;
    assign w_tgt_inc = r_hold_tgt + SW'(1);

    // Only round-robin words time out; a fire always wins over a retarget.
    assign w_timeout = w_full && !w_fire && r_hold_mode
                       && (r_wait == LP_TO_LAST);

    // A back-to-back round-robin load must see the pointer the fire produces.
    assign w_rr_next  = (w_fire && r_hold_mode) ? w_tgt_inc : r_rr_ptr;
    assign w_load_tgt = mode ? w_rr_next : in_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_hold_data <= '0;
            r_hold_tgt  <= '0;
            r_hold_mode <= 1'b0;
            r_out_valid <= '0;
            r_rr_ptr    <= '0;
            r_sent      <= '0;
            r_skip      <= '0;
            r_wait      <= '0;
        end else begin
            if (w_fire) begin
                r_sent <= r_sent + 8'd1;
                if (r_hold_mode) begin
                    r_rr_ptr <= w_tgt_inc;
                end
            end
            unique case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= S_FULL;
                        r_hold_data <= in_data;
                        r_hold_mode <= mode;
                        r_hold_tgt  <= w_load_tgt;
                        r_out_valid <= f_onehot(w_load_tgt);
                        r_wait      <= '0;
                    end
                end
                S_FULL: begin
                    if (w_fire) begin
                        r_wait <= '0;
                        if (w_accept) begin
                            r_hold_data <= in_data;
                            r_hold_mode <= mode;
                            r_hold_tgt  <= w_load_tgt;
                            r_out_valid <= f_onehot(w_load_tgt);
                        end else begin
                            r_state     <= S_EMPTY;
                            r_out_valid <= '0;
                        end
                    end else if (w_timeout) begin
                        r_hold_tgt  <= w_tgt_inc;
                        r_out_valid <= f_onehot(w_tgt_inc);
                        r_wait      <= '0;
                        if (r_skip != 8'hFF) begin
                            r_skip <= r_skip + 8'd1;
                        end
                    end else if (r_hold_mode) begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_hold_data;
    assign rr_ptr    = r_rr_ptr;
    assign sent_cnt  = r_sent;
    assign skip_cnt  = r_skip;

endmodule

// File: tb/tb_dmux_dispatch.sv
// tb_dmux_dispatch: directed scenario checks for dmux_dispatch.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_dmux_dispatch;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] out_data;
    logic [1:0]  rr_ptr;
    logic [7:0]  sent_cnt;
    logic [7:0]  skip_cnt;

    int n_vec = 0;
    int n_err = 0;

    dmux_dispatch #(
        .WIDTH(16),
        .N_OUT(4),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mode(mode),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_sel(in_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .rr_ptr(rr_ptr),
        .sent_cnt(sent_cnt),
        .skip_cnt(skip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        mode      = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        mode      = 1'b0;
        in_data   = 16'hFFFF;
        in_sel    = 2'd1;
        out_ready = 4'hF;
        tick();
        tick();
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_ready got %b exp 0", in_ready);
        end
        n_vec++;
        if (out_valid !== 4'b0000 || out_data !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_out got v=%b d=%h exp v=0000 d=0000", out_valid, out_data);
        end
        n_vec++;
        if (rr_ptr !== 2'd0 || sent_cnt !== 8'd0 || skip_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_cnt got rr=%0d sent=%0d skip=%0d exp 0 0 0", rr_ptr, sent_cnt, skip_cnt);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_addressed();
        do_reset();
        out_ready = 4'hF;
        mode      = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        in_sel    = 2'd2;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 4'b0100 || out_data !== 16'h1234) begin
            n_err++;
            $display("FAIL addr_deliver got v=%b d=%h exp v=0100 d=1234", out_valid, out_data);
        end
        tick();
        n_vec++;
        if (out_valid !== 4'b0000 || sent_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL addr_after got v=%b sent=%0d exp v=0000 sent=1", out_valid, sent_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_v;
        do_reset();
        out_ready = 4'hF;
        mode      = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0100 + 16'(i);
            in_sel   = 2'd3;
            #1;
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL rr_burst_ready[%0d] got %b exp 1", i, in_ready);
            end
            tick();
            exp_v = 4'(1 << (i % 4));
            n_vec++;
            if (out_valid !== exp_v || out_data !== 16'h0100 + 16'(i)) begin
                n_err++;
                $display("FAIL rr_burst_tgt[%0d] got v=%b d=%h exp v=%b d=%h", i, out_valid, out_data, exp_v, 16'h0100 + 16'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if (out_valid !== 4'b0000 || rr_ptr !== 2'd2 || sent_cnt !== 8'd6) begin
            n_err++;
            $display("FAIL rr_burst_end got v=%b rr=%0d sent=%0d exp v=0000 rr=2 sent=6", out_valid, rr_ptr, sent_cnt);
        end
    endtask

    task automatic test_rr_timeout();
        do_reset();
        out_ready = 4'b1110;
        mode      = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            n_vec++;
            if (out_valid !== 4'b0001 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL rr_hold[%0d] got v=%b rdy=%b exp v=0001 rdy=0", c, out_valid, in_ready);
            end
            tick();
        end
        n_vec++;
        if (out_valid !== 4'b0010 || out_data !== 16'hBEEF || skip_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL rr_retarget got v=%b d=%h skip=%0d exp v=0010 d=beef skip=1", out_valid, out_data, skip_cnt);
        end
        n_vec++;
        if (rr_ptr !== 2'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rr_retarget_ptr got rr=%0d rdy=%b exp rr=0 rdy=1", rr_ptr, in_ready);
        end
        tick();
        n_vec++;
        if (out_valid !== 4'b0000 || sent_cnt !== 8'd1 || rr_ptr !== 2'd2 || skip_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL rr_timeout_end got v=%b sent=%0d rr=%0d skip=%0d exp 0000 1 2 1", out_valid, sent_cnt, rr_ptr, skip_cnt);
        end
    endtask

    task automatic test_addr_stall();
        do_reset();
        out_ready = 4'b0111;
        mode      = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd3;
        in_data   = 16'hA5A5;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            n_vec++;
            if (out_valid !== 4'b1000 || in_ready !== 1'b0 || skip_cnt !== 8'd0) begin
                n_err++;
                $display("FAIL addr_stall[%0d] got v=%b rdy=%b skip=%0d exp 1000 0 0", c, out_valid, in_ready, skip_cnt);
            end
            tick();
        end
        out_ready = 4'b1000;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_data !== 16'hA5A5) begin
            n_err++;
            $display("FAIL addr_stall_release got rdy=%b d=%h exp rdy=1 d=a5a5", in_ready, out_data);
        end
        tick();
        n_vec++;
        if (out_valid !== 4'b0000 || sent_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL addr_stall_done got v=%b sent=%0d exp 0000 1", out_valid, sent_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 4'hF;
        mode      = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0001;
        tick();
        in_valid  = 1'b0;
        tick();
        out_ready = 4'h0;
        in_valid  = 1'b1;
        in_data   = 16'h7777;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        n_vec++;
        if (out_valid !== 4'b0100 || sent_cnt !== 8'd1 || skip_cnt !== 8'd1 || rr_ptr !== 2'd1) begin
            n_err++;
            $display("FAIL mid_pre got v=%b sent=%0d skip=%0d rr=%0d exp 0100 1 1 1", out_valid, sent_cnt, skip_cnt, rr_ptr);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_in_ready got %b exp 0", in_ready);
        end
        tick();
        n_vec++;
        if (out_valid !== 4'b0000 || out_data !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_out got v=%b d=%h exp 0000 0000", out_valid, out_data);
        end
        n_vec++;
        if (rr_ptr !== 2'd0 || sent_cnt !== 8'd0 || skip_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL mid_cnt got rr=%0d sent=%0d skip=%0d exp 0 0 0", rr_ptr, sent_cnt, skip_cnt);
        end
        out_ready = 4'hF;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        n_vec++;
        if (out_valid !== 4'b0000 || sent_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL mid_no_deliver got v=%b sent=%0d exp 0000 0", out_valid, sent_cnt);
        end
    endtask

    task automatic test_mode_toggle();
        do_reset();
        out_ready = 4'hF;
        mode      = 1'b0;
        for (int i = 0; i < 255; i++) begin
            in_valid = 1'b1;
            in_sel   = 2'(i);
            in_data  = 16'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if (sent_cnt !== 8'd255 || rr_ptr !== 2'd0) begin
            n_err++;
            $display("FAIL preload got sent=%0d rr=%0d exp 255 0", sent_cnt, rr_ptr);
        end
        out_ready = 4'h0;
        mode      = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 16'h1111;
        tick();
        in_valid = 1'b0;
        mode     = 1'b1;
        repeat (12) tick();
        n_vec++;
        if (out_valid !== 4'b0010 || skip_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL toggle_hold got v=%b skip=%0d exp 0010 0", out_valid, skip_cnt);
        end
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_sel    = 2'd3;
        in_data   = 16'h2222;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL toggle_ready got %b exp 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (sent_cnt !== 8'd0 || out_valid !== 4'b0001 || out_data !== 16'h2222) begin
            n_err++;
            $display("FAIL toggle_wrap got sent=%0d v=%b d=%h exp 0 0001 2222", sent_cnt, out_valid, out_data);
        end
        tick();
        n_vec++;
        if (sent_cnt !== 8'd1 || rr_ptr !== 2'd1 || out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL toggle_end got sent=%0d rr=%0d v=%b exp 1 1 0000", sent_cnt, rr_ptr, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_addressed();
        test_back_to_back();
        test_rr_timeout();
        test_addr_stall();
        test_reset_mid();
        test_mode_toggle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
